// File: rtl/arb_rr_4.sv
// arb_rr_4 -- four-requester round-robin arbiter with bounded hold time.
//
// A requester keeps the grant for as long as it holds its request. Once it
// has held the grant for MAX_HOLD consecutive cycles and another requester
// is waiting, the grant moves on. The search for the next winner always
// starts just after the previous holder, so every requester is served in
// turn.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   req[3:0]   request lines, one per requester
//   gnt[3:0]   one-hot grant, all-zero when nobody holds the resource
//   gnt_idx    binary index of the current grantee (0 when idle)
//   gnt_valid  high exactly when gnt is non-zero
//   hold_cnt   cycles the current grant has been held, saturating at MAX_HOLD
module arb_rr_4 #(
    parameter int unsigned MAX_HOLD = 8  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic [3:0] hold_cnt
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] hold_q, hold_d;

    // Round-robin search: first set bit of mask in order start, start+1, ...
    // (mod 4). Returns {found, index}. Scanning from the far end backwards
    // lets the earliest position in search order overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] pos;
        result = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            pos = start + 2'(k);
            if (mask[pos]) result = {1'b1, pos};
        end
        return result;
    endfunction

    logic [3:0] holder_oh;   // one-hot of the current holder
    logic [3:0] others;      // pending requests excluding the holder
    logic [1:0] after_idx;   // position just after the holder
    logic [2:0] idle_pick;
    logic [2:0] next_pick;
    logic       holder_req;

    assign holder_oh  = 4'b0001 << idx_q;
    assign others     = req & ~holder_oh;
    assign after_idx  = idx_q + 2'd1;
    assign holder_req = req[idx_q];
    assign idle_pick  = rr_pick(req, ptr_q);
    assign next_pick  = rr_pick(others, after_idx);

    // NOTE: every next-state signal gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (idle_pick[2]) begin
                    state_d = BUSY;
                    idx_d   = idle_pick[1:0];
                    hold_d  = 4'd1;
                end
            end
            BUSY: begin
                if (!holder_req) begin
                    // Release wins over preemption when both apply.
                    ptr_d = after_idx;
                    if (next_pick[2]) begin
                        idx_d  = next_pick[1:0];
                        hold_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        hold_d  = 4'd0;
                    end
                end else if (hold_q >= HOLD_MAX && next_pick[2]) begin
                    // Preemption: holder used its full slot and someone waits.
                    ptr_d  = after_idx;
                    idx_d  = next_pick[1:0];
                    hold_d = 4'd1;
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_valid = (state_q == BUSY);
    assign gnt_idx   = idx_q;
    assign hold_cnt  = hold_q;
    assign gnt       = gnt_valid ? holder_oh : 4'b0000;

endmodule

// File: tb/tb_arb_rr_4.sv
// Directed testbench for arb_rr_4 with MAX_HOLD = 8. Inputs change shortly
// after a rising edge; outputs are observed 1 time unit after the next edge.
module tb_arb_rr_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic [3:0] hold_cnt;

    logic [3:0] req_dec;   // req as sampled at the deciding edge
    int         errors;
    int         checks;

    arb_rr_4 #(.MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture req at the edge, settle, then check invariants.
    task automatic cycle();
        @(posedge clk);
        req_dec = req;
        #1;
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        check("valid_eq_nonzero", 32'(gnt_valid), 32'(gnt != 4'b0000));
        check("gnt_subset_req", 32'(gnt & ~req_dec), 32'd0);
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] g,
                              input logic [3:0] h);
        check({tag, "_gnt"}, 32'(gnt), 32'(g));
        check({tag, "_hold"}, 32'(hold_cnt), 32'(h));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_g;
        errors  = 0;
        checks  = 0;
        req     = 4'b0000;
        req_dec = 4'b0000;
        rst     = 1'b0;

        // Reset state
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_idx", 32'(gnt_idx), 32'd0);
        check("rst_valid", 32'(gnt_valid), 32'd0);
        check("rst_hold", 32'(hold_cnt), 32'd0);
        check("rst_ptr", 32'(dut.ptr_q), 32'd0);

        // Idle with no requests stays idle
        cycle();
        expect_gnt("idle", 4'b0000, 4'd0);

        // req=1010 from ptr 0 -> requester 1
        req = 4'b1010;
        cycle();
        expect_gnt("first", 4'b0010, 4'd1);
        check("first_idx", 32'(gnt_idx), 32'd1);
        // Release with nothing else pending -> idle, ptr = 2
        req = 4'b0000;
        cycle();
        expect_gnt("rel_idle", 4'b0000, 4'd0);
        check("rel_idle_idx", 32'(gnt_idx), 32'd0);
        check("rel_idle_ptr", 32'(dut.ptr_q), 32'd2);

        // All four requesting: 8 cycles each, 0,1,2,3,0 with no gaps
        do_reset();
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            exp_g = 4'b0001 << (s % 4);
            for (int h = 1; h <= 8; h++) begin
                cycle();
                expect_gnt($sformatf("rr_s%0d_h%0d", s, h), exp_g, 4'(h));
            end
        end
        // One more cycle: preemption of 0 moves the grant to 1
        cycle();
        expect_gnt("rr_preempt", 4'b0010, 4'd1);
        check("rr_preempt_ptr", 32'(dut.ptr_q), 32'd1);

        // Grant on 3, then only requester 0: wrap-around 3 -> 0
        do_reset();
        req = 4'b1000;
        cycle();
        expect_gnt("g3", 4'b1000, 4'd1);
        req = 4'b0001;
        cycle();
        expect_gnt("wrap", 4'b0001, 4'd1);
        check("wrap_ptr", 32'(dut.ptr_q), 32'd0);

        // Single requester 2 for 20 cycles: saturates at 8, never preempted
        req = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            expect_gnt($sformatf("solo_%0d", k), 4'b0100,
                       (k < 8) ? 4'(k) : 4'd8);
        end

        // Grant 0 up to hold 8, then 0 drops while 1 requests: release
        req = 4'b0001;
        for (int k = 1; k <= 8; k++) cycle();
        expect_gnt("g0_full", 4'b0001, 4'd8);
        req = 4'b0010;
        cycle();
        expect_gnt("rel_vs_pre", 4'b0010, 4'd1);
        check("rel_vs_pre_ptr", 32'(dut.ptr_q), 32'd1);

        // Grant 2, then reset mid-grant, then resume
        req = 4'b0100;
        cycle();
        expect_gnt("g2", 4'b0100, 4'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        expect_gnt("mid_rst", 4'b0000, 4'd0);
        check("mid_rst_idx", 32'(gnt_idx), 32'd0);
        check("mid_rst_valid", 32'(gnt_valid), 32'd0);
        cycle();
        expect_gnt("resume", 4'b0100, 4'd1);

        // Idle from ptr 3 with req=0011: order 3,0,1,2 -> requester 0
        req = 4'b0000;
        cycle();
        expect_gnt("idle2", 4'b0000, 4'd0);
        check("idle2_ptr", 32'(dut.ptr_q), 32'd3);
        req = 4'b0011;
        cycle();
        expect_gnt("ptr3_pick", 4'b0001, 4'd1);
        check("ptr3_pick_idx", 32'(gnt_idx), 32'd0);

        // Preemption skips the non-requesting: 0 held 8 with req=1001 -> 3
        req = 4'b0001;
        for (int k = 2; k <= 8; k++) cycle();
        expect_gnt("g0_full2", 4'b0001, 4'd8);
        req = 4'b1001;
        cycle();
        expect_gnt("pre_to3", 4'b1000, 4'd1);
        check("pre_to3_ptr", 32'(dut.ptr_q), 32'd1);
        // Preempted requester 0 still waiting: 3 holds, hold counts up
        cycle();
        expect_gnt("g3_keep", 4'b1000, 4'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
